// File: rtl/mem_stage.sv
// mem_stage -- memory access stage of the in-order pipeline.
//
// Accepts one instruction per cycle from EX, forms the load result from
// synchronous SRAM read data, and hands the instruction to WB. The SRAM
// returns data only in the first cycle an instruction sits in MEM, so that
// data is captured in a hold register if WB stalls on that cycle.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   ex_mem_valid      EX holds a valid instruction for MEM
//   mem_allowin       MEM can accept from EX this cycle
//   ex_mem_bus[189:0] gr_we, res_from_mem, mem_type, addr_low2, dest, pc,
//                     inst, result, csr_we, csr_re, csr_num, csr_wmask,
//                     csr_wvalue, ertn, syscall (MSB->LSB)
//   data_sram_rdata   SRAM read data for the address EX issued last cycle
//   mem_wb_valid      MEM presents a valid instruction to WB
//   wb_allowin        WB can accept this cycle
//   mem_wb_bus[183:0] gr_we, dest, pc, inst, final_result, csr_we, csr_re,
//                     csr_num, csr_wmask, csr_wvalue, ertn, syscall
//   mem_id_bus[38:0]  {mem_bypass, dest, final_result, mem_csr} to ID
//   mem_ex            valid instruction raising syscall/ertn
//   wb_ex, ertn_flush pipeline flush requests from WB
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_mem_valid,
  output logic         mem_allowin,
  input  logic [189:0] ex_mem_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic         mem_wb_valid,
  input  logic         wb_allowin,
  output logic [183:0] mem_wb_bus,
  output logic [38:0]  mem_id_bus,
  output logic         mem_ex,
  input  logic         wb_ex,
  input  logic         ertn_flush
);

  logic         mem_valid_q, mem_valid_d;
  logic [189:0] bus_q, bus_d;
  logic         hold_vld_q, hold_vld_d;
  logic [31:0]  hold_rdata_q, hold_rdata_d;

  logic         mem_ready_go;
  logic         flush;
  logic         leave;

  logic         gr_we;
  logic         res_from_mem;
  logic [2:0]   mem_type;
  logic [1:0]   addr_low2;
  logic [4:0]   dest;
  logic [31:0]  pc;
  logic [31:0]  inst;
  logic [31:0]  result;
  logic         csr_we;
  logic         csr_re;
  logic [13:0]  csr_num;
  logic [31:0]  csr_wmask;
  logic [31:0]  csr_wvalue;
  logic         ertn;
  logic         syscall;

  logic [31:0]  ld_src;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;
  logic [31:0]  ld_result;
  logic [31:0]  final_result;

  assign {gr_we, res_from_mem, mem_type, addr_low2, dest, pc, inst, result,
          csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall} = bus_q;

  // Handshake
  assign mem_ready_go = 1'b1;
  assign mem_wb_valid = mem_valid_q & mem_ready_go;
  assign mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);
  assign flush        = wb_ex | ertn_flush;
  assign leave        = mem_wb_valid & wb_allowin;

  always_comb begin
    mem_valid_d  = mem_valid_q;
    bus_d        = bus_q;
    hold_vld_d   = hold_vld_q;
    hold_rdata_d = hold_rdata_q;

    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_mem_valid;
    end

    // A flushing cycle never loads a new payload; the old one stays put.
    if (ex_mem_valid & mem_allowin & ~flush) begin
      bus_d = ex_mem_bus;
    end

    // SRAM data is only meaningful in the first MEM cycle; keep it if WB stalls.
    if (flush | leave) begin
      hold_vld_d = 1'b0;
    end else if (mem_valid_q & ~wb_allowin & ~hold_vld_q) begin
      hold_vld_d   = 1'b1;
      hold_rdata_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      hold_vld_q  <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      hold_vld_q  <= hold_vld_d;
    end
  end

  // Payload registers carry no reset; mem_valid_q / hold_vld_q qualify them.
  always_ff @(posedge clk) begin
    bus_q        <= bus_d;
    hold_rdata_q <= hold_rdata_d;
  end

  // Load data formatting
  assign ld_src = hold_vld_q ? hold_rdata_q : data_sram_rdata;

  always_comb begin
    ld_byte = 8'h00;
    case (addr_low2)
      2'b00:   ld_byte = ld_src[7:0];
      2'b01:   ld_byte = ld_src[15:8];
      2'b10:   ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
  end

  assign ld_half = addr_low2[1] ? ld_src[31:16] : ld_src[15:0];

  always_comb begin
    ld_result = ld_src;
    case (mem_type)
      3'b001:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_result = {24'h000000, ld_byte};
      3'b100:  ld_result = {16'h0000, ld_half};
      default: ld_result = ld_src;
    endcase
  end

  assign final_result = res_from_mem ? ld_result : result;

  // Outputs
  assign mem_wb_bus = {gr_we, dest, pc, inst, final_result, csr_we, csr_re,
                       csr_num, csr_wmask, csr_wvalue, ertn, syscall};

  assign mem_id_bus = {mem_valid_q & gr_we, dest, final_result,
                       mem_valid_q & (csr_we | csr_re)};

  assign mem_ex = mem_valid_q & (syscall | ertn);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ex_mem_valid;
  logic         mem_allowin;
  logic [189:0] ex_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic         mem_wb_valid;
  logic         wb_allowin;
  logic [183:0] mem_wb_bus;
  logic [38:0]  mem_id_bus;
  logic         mem_ex;
  logic         wb_ex;
  logic         ertn_flush;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ex_mem_valid    (ex_mem_valid),
    .mem_allowin     (mem_allowin),
    .ex_mem_bus      (ex_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_wb_valid    (mem_wb_valid),
    .wb_allowin      (wb_allowin),
    .mem_wb_bus      (mem_wb_bus),
    .mem_id_bus      (mem_id_bus),
    .mem_ex          (mem_ex),
    .wb_ex           (wb_ex),
    .ertn_flush      (ertn_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        gr_we;
    logic        rfm;
    logic [2:0]  mt;
    logic [1:0]  al;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic        csr_we;
    logic        csr_re;
    logic        ertn;
    logic        sys;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] rdata;
    logic [31:0] fin;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;
  logic [183:0] cur_exp;
  logic [183:0] exp_q [$];

  task automatic chk(input string nm, input logic [189:0] act, input logic [189:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic gr_we, input logic rfm, input logic [2:0] mt,
                                input logic [1:0] al, input logic [31:0] result,
                                input logic [7:0] tag);
    instr_t x;
    x.gr_we  = gr_we;
    x.rfm    = rfm;
    x.mt     = mt;
    x.al     = al;
    x.dest   = tag[4:0];
    x.pc     = 32'h1c00_0000 + {22'd0, tag, 2'b00};
    x.inst   = 32'h0280_0000 | {24'd0, tag};
    x.result = result;
    x.csr_we = tag[1];
    x.csr_re = tag[2];
    x.ertn   = 1'b0;
    x.sys    = 1'b0;
    return x;
  endfunction

  function automatic logic [189:0] ex_of(input instr_t x);
    return {x.gr_we, x.rfm, x.mt, x.al, x.dest, x.pc, x.inst, x.result,
            x.csr_we, x.csr_re, x.pc[15:2], ~x.inst, x.result ^ x.pc, x.ertn, x.sys};
  endfunction

  function automatic logic [183:0] wb_of(input instr_t x, input logic [31:0] fin);
    return {x.gr_we, x.dest, x.pc, x.inst, fin,
            x.csr_we, x.csr_re, x.pc[15:2], ~x.inst, x.result ^ x.pc, x.ertn, x.sys};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input instr_t x, input logic [31:0] fin);
    ex_mem_valid = 1'b1;
    ex_mem_bus   = ex_of(x);
    cur_exp      = wb_of(x, fin);
  endtask

  task automatic idle();
    ex_mem_valid = 1'b0;
  endtask

  // Scoreboard: push on EX->MEM handshake, pop/compare on MEM->WB handshake.
  always @(negedge clk) begin
    logic [183:0] e;
    if (reset) begin
      exp_q.delete();
    end else if (wb_ex || ertn_flush) begin
      if (mem_wb_valid && exp_q.size() > 0) e = exp_q.pop_front();
    end else begin
      if (mem_wb_valid && wb_allowin) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_out", 190'(1'b1), 190'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_wb_bus", 190'(mem_wb_bus), 190'(e));
          chk("sb_id_bus", 190'(mem_id_bus),
              190'({e[183], e[182:178], e[113:82], e[81] | e[80]}));
          chk("sb_mem_ex", 190'(mem_ex), 190'(e[1] | e[0]));
        end
      end
      if (ex_mem_valid && mem_allowin) exp_q.push_back(cur_exp);
    end
  end

  task automatic run_table(input bit stall);
    int i = 0;
    int guard = 0;
    bit pend = 1'b0;
    logic [31:0] pend_rd = 32'h0;
    while ((i < NV || pend) && guard < 400) begin
      step();
      guard++;
      data_sram_rdata = pend ? pend_rd : $urandom;
      pend = 1'b0;
      wb_allowin = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (i < NV) drive(vt[i].ins, vt[i].fin);
      else idle();
      smp();
      if (ex_mem_valid && mem_allowin) begin
        pend    = 1'b1;
        pend_rd = vt[i].rdata;
        i++;
      end
    end
    if (guard >= 400) chk("table_timeout", 190'(guard), 190'(0));
    wb_allowin = 1'b1;
    idle();
    repeat (4) step();
  endtask

  initial begin : main
    logic [183:0] snap;
    instr_t a;
    instr_t b;

    vt[0]  = '{mk(1, 1, 3'b000, 2'b00, 32'h0, 8'd1),  32'h1234_5678, 32'h1234_5678};
    vt[1]  = '{mk(1, 1, 3'b001, 2'b11, 32'h0, 8'd2),  32'h80FF_1234, 32'hFFFF_FF80};
    vt[2]  = '{mk(0, 1, 3'b001, 2'b00, 32'h0, 8'd3),  32'h80FF_1234, 32'h0000_0034};
    vt[3]  = '{mk(1, 1, 3'b001, 2'b01, 32'h0, 8'd4),  32'h80FF_1234, 32'h0000_0012};
    vt[4]  = '{mk(1, 1, 3'b011, 2'b10, 32'h0, 8'd5),  32'h80FF_1234, 32'h0000_00FF};
    vt[5]  = '{mk(0, 1, 3'b011, 2'b11, 32'h0, 8'd6),  32'h80FF_1234, 32'h0000_0080};
    vt[6]  = '{mk(1, 1, 3'b010, 2'b00, 32'h0, 8'd7),  32'h0000_8001, 32'hFFFF_8001};
    vt[7]  = '{mk(1, 1, 3'b010, 2'b11, 32'h0, 8'd8),  32'h7FFF_0000, 32'h0000_7FFF};
    vt[8]  = '{mk(1, 1, 3'b100, 2'b10, 32'h0, 8'd9),  32'h9ABC_0000, 32'h0000_9ABC};
    vt[9]  = '{mk(1, 1, 3'b100, 2'b01, 32'h0, 8'd10), 32'h9ABC_F00D, 32'h0000_F00D};
    vt[10] = '{mk(1, 1, 3'b101, 2'b01, 32'h0, 8'd11), 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[11] = '{mk(0, 1, 3'b111, 2'b10, 32'h0, 8'd12), 32'hCAFE_F00D, 32'hCAFE_F00D};
    vt[12] = '{mk(1, 0, 3'b001, 2'b11, 32'h55AA_55AA, 8'd13), 32'h1111_1111, 32'h55AA_55AA};
    vt[13] = '{mk(1, 1, 3'b110, 2'b00, 32'h0, 8'd14), 32'h0BAD_F00D, 32'h0BAD_F00D};

    reset = 1'b1;
    ex_mem_valid = 1'b0;
    ex_mem_bus = '0;
    data_sram_rdata = 32'h0;
    wb_allowin = 1'b1;
    wb_ex = 1'b0;
    ertn_flush = 1'b0;
    cur_exp = '0;

    @(posedge clk);
    smp();
    chk("rst_wb_valid", 190'(mem_wb_valid), 190'(1'b0));
    chk("rst_allowin",  190'(mem_allowin),  190'(1'b1));
    chk("rst_bypass",   190'(mem_id_bus[38]), 190'(1'b0));
    chk("rst_csr",      190'(mem_id_bus[0]),  190'(1'b0));
    chk("rst_mem_ex",   190'(mem_ex),         190'(1'b0));
    step();
    reset = 1'b0;

    run_table(1'b0);
    run_table(1'b1);

    // ld.b latency and sign extension
    step(); drive(vt[1].ins, vt[1].fin); data_sram_rdata = 32'h0;
    smp();  chk("ldb_not_yet_valid", 190'(mem_wb_valid), 190'(1'b0));
    step(); idle(); data_sram_rdata = 32'h80FF_1234;
    smp();  chk("ldb_valid", 190'(mem_wb_valid), 190'(1'b1));
            chk("ldb_final", 190'(mem_wb_bus[113:82]), 190'(32'hFFFF_FF80));
    step(); smp(); chk("ldb_gone", 190'(mem_wb_valid), 190'(1'b0));

    // ld.hu with bypass
    step(); drive(vt[8].ins, vt[8].fin);
    step(); idle(); data_sram_rdata = 32'h9ABC_0000;
    smp();  chk("ldhu_final",  190'(mem_id_bus[32:1]), 190'(32'h0000_9ABC));
            chk("ldhu_bypass", 190'(mem_id_bus[38]),   190'(1'b1));

    // WB stall: ld.w data must survive changing SRAM data
    a = mk(1, 1, 3'b000, 2'b00, 32'h0, 8'd20);
    b = mk(0, 0, 3'b000, 2'b00, 32'h77, 8'd21);
    step(); drive(a, 32'h1111_1111);
    step(); drive(b, 32'h0000_0077); data_sram_rdata = 32'h1111_1111; wb_allowin = 1'b0;
    smp();  chk("stall_allowin", 190'(mem_allowin), 190'(1'b0));
            chk("stall_final", 190'(mem_wb_bus[113:82]), 190'(32'h1111_1111));
            snap = mem_wb_bus;
    for (int k = 0; k < 2; k++) begin
      step(); data_sram_rdata = 32'h2222_2222 + 32'(k);
      smp();  chk("stall_allowin_hold", 190'(mem_allowin), 190'(1'b0));
              chk("stall_bus_stable", 190'(mem_wb_bus), 190'(snap));
    end
    step(); wb_allowin = 1'b1; data_sram_rdata = 32'h4444_4444;
    smp();  chk("stall_release_final", 190'(mem_wb_bus[113:82]), 190'(32'h1111_1111));
            chk("stall_release_allowin", 190'(mem_allowin), 190'(1'b1));
    step(); idle();
    smp();  chk("stall_next_valid", 190'(mem_wb_valid), 190'(1'b1));
            chk("stall_next_final", 190'(mem_wb_bus[113:82]), 190'(32'h0000_0077));
    step();

    // Exception flush while stalled
    a = mk(1, 0, 3'b000, 2'b00, 32'hA5A5_A5A5, 8'd22);
    step(); drive(a, 32'hA5A5_A5A5); wb_allowin = 1'b0;
    step(); idle();
    smp();  snap = mem_wb_bus;
    step(); wb_ex = 1'b1;
    smp();  chk("flush_hold_set", 190'(dut.hold_vld_q), 190'(1'b1));
    step(); wb_ex = 1'b0;
    smp();  chk("flush_wb_valid", 190'(mem_wb_valid),   190'(1'b0));
            chk("flush_bypass",   190'(mem_id_bus[38]), 190'(1'b0));
            chk("flush_hold_clr", 190'(dut.hold_vld_q), 190'(1'b0));
            chk("flush_bus_kept", 190'(mem_wb_bus),     190'(snap));

    // ERTN flush
    step(); drive(mk(1, 0, 3'b000, 2'b00, 32'h5, 8'd23), 32'h5);
    step(); idle(); ertn_flush = 1'b1;
    step(); ertn_flush = 1'b0;
    smp();  chk("ertn_flush_valid", 190'(mem_wb_valid), 190'(1'b0));

    // Reset in the middle of a stall drops the instruction
    step(); drive(mk(1, 0, 3'b000, 2'b00, 32'h6, 8'd24), 32'h6);
    step(); idle();
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    smp();  chk("rst_stall_valid",   190'(mem_wb_valid), 190'(1'b0));
            chk("rst_stall_allowin", 190'(mem_allowin),  190'(1'b1));
    step(); wb_allowin = 1'b1;

    // Back-to-back ALU results 1..4
    for (int k = 1; k <= 4; k++) begin
      step(); drive(mk(1, 0, 3'b000, 2'b00, 32'(k), 8'(24 + k)), 32'(k));
      smp();
      if (k > 1) begin
        chk("b2b_valid", 190'(mem_wb_valid), 190'(1'b1));
        chk("b2b_result", 190'(mem_wb_bus[113:82]), 190'(k - 1));
      end
    end
    step(); idle();
    smp();  chk("b2b_valid", 190'(mem_wb_valid), 190'(1'b1));
            chk("b2b_result", 190'(mem_wb_bus[113:82]), 190'(32'd4));
    step(); smp(); chk("b2b_end", 190'(mem_wb_valid), 190'(1'b0));

    // Syscall
    a = mk(0, 0, 3'b000, 2'b00, 32'h9, 8'd30);
    a.sys = 1'b1;
    step(); drive(a, 32'h9); wb_allowin = 1'b0;
    step(); idle();
    smp();  chk("sys_mem_ex", 190'(mem_ex), 190'(1'b1));
            chk("sys_bus_bit", 190'(mem_wb_bus[0]), 190'(1'b1));
    step(); wb_allowin = 1'b1;
    step(); smp(); chk("sys_mem_ex_clr", 190'(mem_ex), 190'(1'b0));

    repeat (3) step();
    chk("sb_drain", 190'(exp_q.size()), 190'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
